// File: rtl/memory_access_stage.sv
// memory_access_stage: single-outstanding load/store unit with alignment check, lane steering and ack timeout.
module memory_access_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [63:0] wb_data,
  output logic        mem_done,
  output logic        misaligned,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] addr_q, sdata_q, rdata_q, sh, load_val;
  logic [1:0] size_q;
  logic load_q, store_q, uns_q, mis_q, err_q;
  logic accept, mem_op, aligned, req, done, timeout;
  logic [2:0] off;
  logic [7:0] mask;
  assign accept  = state_q == IDLE && mem_enable;
  assign mem_op  = is_load || is_store;
  assign aligned = mem_size == 2'd0 || (mem_size == 2'd1 && !alu_result[0]) ||
                   (mem_size == 2'd2 && alu_result[1:0] == 2'd0) || alu_result[2:0] == 3'd0;
  assign req     = state_q == REQ;
  assign done    = state_q == DONE;
  assign timeout = req && !dmem_ack && cnt_q == CW'(MAX_WAIT - 1);
  always_comb begin
    state_d = accept ? ((mem_op && aligned) ? REQ : DONE) :
              req    ? ((dmem_ack || timeout) ? DONE : REQ) :
              done   ? IDLE : state_q;
    cnt_d   = req ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= alu_result;
        sdata_q <= store_data;
        size_q  <= mem_size;
        load_q  <= is_load;
        store_q <= is_store;
        uns_q   <= mem_unsigned;
        mis_q   <= mem_op && !aligned;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
      if (req && dmem_ack) rdata_q <= dmem_rdata;
      if (timeout) err_q <= 1'b1;
    end
  end
  assign off  = addr_q[2:0];
  assign mask = size_q == 2'd0 ? 8'h01 : size_q == 2'd1 ? 8'h03 : size_q == 2'd2 ? 8'h0F : 8'hFF;
  assign sh   = rdata_q >> {off, 3'b000};
  assign load_val = size_q == 2'd0 ? {{56{!uns_q && sh[7]}}, sh[7:0]} :
                    size_q == 2'd1 ? {{48{!uns_q && sh[15]}}, sh[15:0]} :
                    size_q == 2'd2 ? {{32{!uns_q && sh[31]}}, sh[31:0]} : sh;
  // Request-side outputs are held at zero outside REQ so an abandoned request leaves nothing on the bus.
  assign dmem_req   = req;
  assign dmem_we    = req && store_q;
  assign dmem_addr  = req ? {addr_q[63:3], 3'b000} : '0;
  assign dmem_wdata = req ? sdata_q << {off, 3'b000} : '0;
  assign dmem_wstrb = (req && store_q) ? mask << off : '0;
  assign wb_data    = (!done || mis_q || err_q || store_q) ? '0 : load_q ? load_val : addr_q;
  assign mem_done   = done;
  assign misaligned = done && mis_q;
  assign mem_err    = done && err_q;
endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: number of cycles in REQ without dmem_ack before timeout.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_enable  input  1  execute-stage result valid; start request.
REQ-005 SHALL have port alu_result  input  64  effective address (load/store) or ALU result (other ops).
REQ-006 SHALL have port store_data  input  64  rs2 contents for stores.
REQ-007 SHALL have ports is_load, is_store  input  1 each  operation class; both 0 = non-memory op.
REQ-008 SHALL have port mem_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-009 SHALL have port mem_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have ports dmem_req/dmem_we  output  1 each  memory request and write enable.
REQ-011 SHALL have port dmem_addr  output  64  request address, alu_result with bits [2:0] forced to 0.
REQ-012 SHALL have ports dmem_wdata  output  64 and dmem_wstrb  output  8  lane-aligned store data and byte strobes.
REQ-013 SHALL have ports dmem_rdata  input  64 and dmem_ack  input  1  read data, request complete.
REQ-014 SHALL have port wb_data  output  64  writeback value, valid while mem_done=1.
REQ-015 SHALL have ports mem_done, misaligned, mem_err  output  1 each  completion pulse, alignment fault, timeout fault.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DONE.
REQ-017 SHALL, in IDLE with mem_enable=1, register all inputs; go to REQ if memory op and aligned, else DONE; mem_enable outside IDLE ignored.
REQ-018 SHALL define aligned as: byte always; half addr[0]=0; word addr[1:0]=0; double addr[2:0]=0.
REQ-019 SHALL flag misaligned memory op: no dmem_req, wb_data=0, misaligned=1 during the DONE cycle.
REQ-020 SHALL, for non-memory op, set wb_data=registered alu_result in DONE (accept cycle N -> mem_done N+1).
REQ-021 SHALL hold dmem_req=1 and dmem_addr/we/wdata/wstrb stable throughout REQ; dmem_we=is_store.
REQ-022 SHALL compute offset=addr[2:0]; dmem_wstrb=(size mask 0x01/0x03/0x0F/0xFF)<<offset; dmem_wdata=store_data<<(8*offset); loads drive wstrb=0.
REQ-023 SHALL, on dmem_ack=1 in REQ (same cycle as first req allowed), capture dmem_rdata and go to DONE; mem_done asserted the next cycle.
REQ-024 SHALL form load result as (rdata>>(8*offset)) truncated to size, then sign/zero extended to 64; store wb_data=0.
REQ-025 SHALL count REQ cycles; on reaching MAX_WAIT without ack drop dmem_req, go DONE with mem_err=1, wb_data=0.
REQ-026 SHALL assert mem_done for exactly one cycle (DONE), then return to IDLE; minimum initiation interval 2 cycles.
REQ-027 SHALL ignore dmem_ack outside REQ.
REQ-028 SHALL deassert misaligned and mem_err everywhere except DONE of the faulting operation.

Reset
REQ-029 SHALL, with reset=1 at a clock edge, enter IDLE, clear wait counter and registered inputs, drive dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, wb_data, mem_done, misaligned, mem_err to 0.
REQ-030 SHALL abandon an in-flight request on reset mid-REQ; a later dmem_ack for it is ignored.
REQ-031 SHALL give reset priority over mem_enable and dmem_ack in the same cycle.

Verification
REQ-032 SHALL cover non-mem op: alu_result=0x1234, mem_enable at cycle 0 -> mem_done, wb_data=0x1234 at cycle 1, dmem_req never asserted.
REQ-033 SHALL cover signed byte load: addr=0x1003, rdata=0x00000000_80000000 with byte 3=0x80, mem_unsigned=0, ack 2 cycles after req -> dmem_addr=0x1000, wb_data=0xFFFF_FFFF_FFFF_FF80; with mem_unsigned=1 -> 0x80.
REQ-034 SHALL cover half store: addr=0x2006, store_data=0xABCD -> dmem_wstrb=0xC0, dmem_wdata=0xABCD<<48, dmem_we=1, wb_data=0 on done.
REQ-035 SHALL cover misaligned word load addr=0x3002 -> no dmem_req, misaligned=1 and mem_done=1 one cycle after accept.
REQ-036 SHALL cover timeout: MAX_WAIT=4, ack never sent -> dmem_req high 4 cycles, then mem_err=1, mem_done=1, wb_data=0.
REQ-037 SHALL cover reset asserted during REQ then late dmem_ack -> outputs 0, FSM IDLE, no mem_done.
